// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter between instruction fetch and data ports
module mem_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    // instruction fetch port
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ack_o,
    // memory-stage data port
    input  logic        d_ce_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ack_o,
    output logic        bus_err_o,
    output logic        stallreq_o,
    // RAM side
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    input  logic        ram_ack_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_D_BUSY, ST_I_BUSY} state_t;
    typedef enum logic {GRANT_INST, GRANT_DATA} grant_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t      state_q, state_d;
    grant_t      last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        ram_ce_q, ram_ce_d;
    logic        ram_we_q, ram_we_d;
    logic [3:0]  ram_sel_q, ram_sel_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;

    logic [31:0] if_data_q, if_data_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        bus_err_q, bus_err_d;

    // A port being acked this cycle still shows its old ce; mask it so it is not re-granted.
    logic d_req, i_req;
    assign d_req = d_ce_i & ~d_ack_q;
    assign i_req = if_ce_i & ~if_ack_q;

    // Next-state, grant decision and completion handling.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        ram_ce_d     = ram_ce_q;
        ram_we_d     = ram_we_q;
        ram_sel_d    = ram_sel_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        if_data_d    = if_data_q;
        d_rdata_d    = d_rdata_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        bus_err_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (d_req && (!i_req || last_grant_q != GRANT_DATA)) begin
                    state_d      = ST_D_BUSY;
                    last_grant_d = GRANT_DATA;
                    ram_ce_d     = 1'b1;
                    ram_we_d     = d_we_i;
                    ram_sel_d    = d_sel_i;
                    ram_addr_d   = d_addr_i;
                    ram_wdata_d  = d_wdata_i;
                end else if (i_req) begin
                    state_d      = ST_I_BUSY;
                    last_grant_d = GRANT_INST;
                    ram_ce_d     = 1'b1;
                    ram_we_d     = 1'b0;
                    ram_sel_d    = 4'b1111;
                    ram_addr_d   = if_addr_i;
                    ram_wdata_d  = '0;
                end
            end
            ST_D_BUSY, ST_I_BUSY: begin
                if (ram_ack_i || cnt_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    ram_ce_d    = 1'b0;
                    ram_we_d    = 1'b0;
                    ram_sel_d   = '0;
                    ram_addr_d  = '0;
                    ram_wdata_d = '0;
                    bus_err_d   = ~ram_ack_i;
                    if (state_q == ST_D_BUSY) begin
                        d_ack_d = 1'b1;
                        if (!ram_ack_i) begin
                            d_rdata_d = '0;
                        end else if (!ram_we_q) begin
                            d_rdata_d = ram_rdata_i;
                        end
                    end else begin
                        if_ack_d = 1'b1;
                        if (!ram_ack_i) begin
                            if_data_d = '0;
                        end else begin
                            if_data_d = ram_rdata_i;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_INST;
            cnt_q        <= '0;
            ram_ce_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_sel_q    <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            if_data_q    <= '0;
            d_rdata_q    <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            ram_ce_q     <= ram_ce_d;
            ram_we_q     <= ram_we_d;
            ram_sel_q    <= ram_sel_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            if_data_q    <= if_data_d;
            d_rdata_q    <= d_rdata_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign ram_ce_o    = ram_ce_q;
    assign ram_we_o    = ram_we_q;
    assign ram_sel_o   = ram_sel_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign if_data_o   = if_data_q;
    assign d_rdata_o   = d_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign d_ack_o     = d_ack_q;
    assign bus_err_o   = bus_err_q;

    assign stallreq_o = (if_ce_i & ~if_ack_q) | (d_ce_i & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        d_ce_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;
    logic        bus_err_o;
    logic        stallreq_o;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;
    logic        ram_ack_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_ce_i     (if_ce_i),
        .if_addr_i   (if_addr_i),
        .if_data_o   (if_data_o),
        .if_ack_o    (if_ack_o),
        .d_ce_i      (d_ce_i),
        .d_we_i      (d_we_i),
        .d_sel_i     (d_sel_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_rdata_o   (d_rdata_o),
        .d_ack_o     (d_ack_o),
        .bus_err_o   (bus_err_o),
        .stallreq_o  (stallreq_o),
        .ram_ce_o    (ram_ce_o),
        .ram_we_o    (ram_we_o),
        .ram_sel_o   (ram_sel_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i),
        .ram_ack_i   (ram_ack_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic d_req(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdata);
        d_ce_i    = 1'b1;
        d_we_i    = we;
        d_sel_i   = sel;
        d_addr_i  = addr;
        d_wdata_i = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; if_ce_i = 0; if_addr_i = 0; d_ce_i = 0; d_we_i = 0; d_sel_i = 0;
        d_addr_i = 0; d_wdata_i = 0; ram_rdata_i = 0; ram_ack_i = 0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_ram_ce", 32'(ram_ce_o), 0);
        check("rst_ram_addr", ram_addr_o, 0);
        check("rst_if_data", if_data_o, 0);
        check("rst_d_rdata", d_rdata_o, 0);
        check("rst_acks", {29'd0, if_ack_o, d_ack_o, bus_err_o}, 0);
        check("rst_stall", 32'(stallreq_o), 0);

        // single fetch
        if_ce_i = 1; if_addr_i = 32'h40;
        #1 check("f1_stall_req", 32'(stallreq_o), 1);
        step();
        check("f1_ram_ce", 32'(ram_ce_o), 1);
        check("f1_ram_addr", ram_addr_o, 32'h40);
        check("f1_ram_sel", 32'(ram_sel_o), 4'b1111);
        check("f1_ram_we", 32'(ram_we_o), 0);
        check("f1_stall_busy", 32'(stallreq_o), 1);
        ram_ack_i = 1; ram_rdata_i = 32'h3401_1100;
        step();
        ram_ack_i = 0;
        check("f1_if_ack", 32'(if_ack_o), 1);
        check("f1_if_data", if_data_o, 32'h3401_1100);
        check("f1_ram_ce_off", 32'(ram_ce_o), 0);
        check("f1_stall_ack", 32'(stallreq_o), 0);
        if_ce_i = 0;
        step();
        check("f1_if_ack_once", 32'(if_ack_o), 0);

        // simultaneous, last grant INST -> data first
        if_ce_i = 1; if_addr_i = 32'h44;
        d_req(1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
        step();
        check("s_ram_we", 32'(ram_we_o), 1);
        check("s_ram_sel", 32'(ram_sel_o), 4'b0011);
        check("s_ram_addr", ram_addr_o, 32'h100);
        check("s_ram_wdata", ram_wdata_o, 32'hDEAD_BEEF);
        ram_ack_i = 1; ram_rdata_i = 32'h1234_5678;
        step();
        ram_ack_i = 0; d_ce_i = 0;
        check("s_d_ack", 32'(d_ack_o), 1);
        check("s_if_ack_wait", 32'(if_ack_o), 0);
        check("s_d_rdata_keep", d_rdata_o, 0);
        #1 check("s_stall_pend", 32'(stallreq_o), 1);
        step();
        check("s_inst_addr", ram_addr_o, 32'h44);
        check("s_inst_we", 32'(ram_we_o), 0);
        check("s_stall_busy", 32'(stallreq_o), 1);
        ram_ack_i = 1; ram_rdata_i = 32'h1111_2222;
        step();
        ram_ack_i = 0;
        check("s_if_ack", 32'(if_ack_o), 1);
        check("s_if_data", if_data_o, 32'h1111_2222);
        check("s_stall_done", 32'(stallreq_o), 0);
        if_ce_i = 0;
        step();

        // alternation: DATA, INST, DATA
        if_ce_i = 1; if_addr_i = 32'h48;
        d_req(1'b0, 4'b1111, 32'h300, 0);
        step();
        check("a1_addr_data", ram_addr_o, 32'h300);
        ram_ack_i = 1; ram_rdata_i = 32'hA;
        step();
        check("a1_d_ack", 32'(d_ack_o), 1);
        check("a1_d_rdata", d_rdata_o, 32'hA);
        ram_ack_i = 0; d_addr_i = 32'h304;
        step();
        check("a2_addr_inst", ram_addr_o, 32'h48);
        ram_ack_i = 1; ram_rdata_i = 32'hB;
        step();
        check("a2_if_ack", 32'(if_ack_o), 1);
        check("a2_if_data", if_data_o, 32'hB);
        ram_ack_i = 0; if_addr_i = 32'h4C;
        step();
        check("a3_addr_data", ram_addr_o, 32'h304);
        ram_ack_i = 1; ram_rdata_i = 32'hC;
        step();
        check("a3_d_rdata", d_rdata_o, 32'hC);
        ram_ack_i = 0; d_ce_i = 0;
        step();
        check("a4_addr_inst", ram_addr_o, 32'h4C);
        ram_ack_i = 1; ram_rdata_i = 32'hD;
        step();
        check("a4_if_data", if_data_o, 32'hD);
        ram_ack_i = 0; if_ce_i = 0;
        step();

        // RAM wait states
        d_req(1'b0, 4'b1111, 32'h200, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("w_ram_ce", 32'(ram_ce_o), 1);
            check("w_ram_addr", ram_addr_o, 32'h200);
            check("w_no_ack", 32'(d_ack_o), 0);
            if (i == 4) begin
                ram_ack_i = 1; ram_rdata_i = 32'hFF;
            end
            step();
        end
        ram_ack_i = 0; d_ce_i = 0;
        check("w_d_ack", 32'(d_ack_o), 1);
        check("w_d_rdata", d_rdata_o, 32'hFF);
        check("w_ram_ce_off", 32'(ram_ce_o), 0);
        step();
        check("w_ack_once", 32'(d_ack_o), 0);

        // timeout
        d_req(1'b0, 4'b1111, 32'h400, 0);
        step();
        for (int i = 0; i < 16; i++) begin
            check("t_ram_ce", 32'(ram_ce_o), 1);
            check("t_no_ack", 32'(d_ack_o), 0);
            step();
        end
        d_ce_i = 0;
        check("t_d_ack", 32'(d_ack_o), 1);
        check("t_bus_err", 32'(bus_err_o), 1);
        check("t_d_rdata", d_rdata_o, 0);
        check("t_ram_ce_off", 32'(ram_ce_o), 0);
        ram_ack_i = 1; ram_rdata_i = 32'h7777_7777;
        step();
        check("t_stray_ack", 32'(d_ack_o), 0);
        check("t_stray_err", 32'(bus_err_o), 0);
        check("t_stray_ce", 32'(ram_ce_o), 0);
        ram_ack_i = 0;
        step();

        // reset mid-transaction
        d_req(1'b0, 4'b1111, 32'h500, 0);
        step();
        check("r_busy", 32'(ram_ce_o), 1);
        rst = 1; d_ce_i = 0;
        step();
        rst = 0;
        check("r_ram_ce", 32'(ram_ce_o), 0);
        check("r_ram_addr", ram_addr_o, 0);
        check("r_if_data", if_data_o, 0);
        check("r_acks", {30'd0, if_ack_o, d_ack_o}, 0);
        ram_ack_i = 1; ram_rdata_i = 32'h5555_5555;
        step();
        ram_ack_i = 0;
        check("r_late_ack", {30'd0, if_ack_o, d_ack_o}, 0);
        check("r_late_rdata", d_rdata_o, 0);
        d_req(1'b0, 4'b1111, 32'h600, 0);
        step();
        check("r_next_addr", ram_addr_o, 32'h600);
        ram_ack_i = 1; ram_rdata_i = 32'h66;
        step();
        ram_ack_i = 0; d_ce_i = 0;
        check("r_next_ack", 32'(d_ack_o), 1);
        check("r_next_rdata", d_rdata_o, 32'h66);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data/instruction RAM between the instruction-fetch port and the memory-stage data port.
- Grants one transaction at a time and drives the RAM strobes from registered request copies.
- Waits for the RAM handshake, returns read data with a one-cycle ack, and raises a pipeline stall request while any port is unserved.
- Sits between the if/mem stages and the external RAM; stallreq_o feeds the pipeline ctrl block.

Parameters:
TIMEOUT, 16, max cycles to wait for ram_ack_i before aborting a transaction (≥2)
CNT_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  synchronous, active-high reset
if_ce_i  in  1  instruction fetch request (read only)
if_addr_i  in  32  fetch address
if_data_o  out  32  fetched word
if_ack_o  out  1  one-cycle fetch completion pulse
d_ce_i  in  1  data request from memory stage
d_we_i  in  1  1=write, 0=read
d_sel_i  in  4  byte lanes, bit3 = bits[31:24]
d_addr_i  in  32  data address
d_wdata_i  in  32  store data
d_rdata_o  out  32  load data
d_ack_o  out  1  one-cycle data completion pulse
bus_err_o  out  1  pulses with the ack of a timed-out transaction
stallreq_o  out  1  pipeline stall request
ram_ce_o  out  1  RAM chip enable
ram_we_o  out  1  RAM write enable
ram_sel_o  out  4  RAM byte lanes
ram_addr_o  out  32  RAM address
ram_wdata_o  out  32  RAM write data
ram_rdata_i  in  32  RAM read data, valid with ram_ack_i
ram_ack_i  in  1  RAM completion, ignored unless ram_ce_o=1

Behaviour:
- Reset (rst=1 at edge):
  - State IDLE; last_grant=INST; counter=0.
  - All ram_* outputs 0; if_data_o, d_rdata_o 0; if_ack_o, d_ack_o, bus_err_o 0.
  - Reset mid-transaction: ram_ce_o is 0 after that edge, the transaction is dropped, and a late ram_ack_i is ignored.
- Requester rule: each port holds ce/addr/we/sel/wdata stable until its ack pulse. A ce still high in the cycle after its ack is a new request.
- States: IDLE, D_BUSY, I_BUSY.
- IDLE, on each edge:
  - Only d_ce_i=1 → latch data request, go D_BUSY.
  - Only if_ce_i=1 → latch fetch (we=0, sel=4'b1111), go I_BUSY.
  - Both=1 → grant data unless last_grant=DATA, then grant inst. Update last_grant to the granted port.
  - A request whose ack pulses this cycle is not re-granted this cycle.
- BUSY:
  - ram_ce_o=1 and ram_* driven from latched registers; counter increments each cycle.
  - ram_ack_i=1 at an edge → capture ram_rdata_i into the owning port's data output (reads only; writes leave it unchanged). Pulse that port's ack for exactly the next cycle. ram_ce_o=0 next cycle. Go IDLE; counter=0.
  - counter reaches TIMEOUT-1 with no ack → same completion path, but data output=0 and bus_err_o=1 together with the ack.
- Latency: request seen at edge N; ram_ce_o high from N+1. RAM acking combinationally in its first cycle gives ack at edge N+2 (port ack high during cycle N+2).
  - Minimum request-to-request spacing is 3 cycles (IDLE, BUSY, ack/IDLE). The state is IDLE during the ack cycle, so a new grant can occur on the ack cycle's edge.
- Data outputs hold their last value between transactions.
- stallreq_o (combinational) = (if_ce_i & ~if_ack_o) | (d_ce_i & ~d_ack_o).
- Write data and sel pass unchanged; no address alignment checking (done upstream).

Test Plan:
- Single fetch: if_ce_i=1, addr=0x0000_0040; RAM acks 1st busy cycle with 0x3401_1100 → ram_addr_o=0x40, ram_sel_o=4'b1111, ram_we_o=0; if_data_o=0x3401_1100, if_ack_o high 1 cycle at N+2; stallreq_o=1 for cycles N..N+1, 0 at N+2.
- Simultaneous requests, last_grant=INST: if_ce_i=1 and d_ce_i=1 (write 0xDEAD_BEEF, sel 4'b0011, addr 0x100) → data served first; RAM sees we=1, sel=0011; then fetch is granted; d_ack_o precedes if_ack_o; stallreq_o stays 1 until if_ack_o.
- Alternation: three back-to-back cycles of both ports requesting → grant order DATA, INST, DATA.
- RAM wait states: ack delayed 5 cycles on a load (addr 0x200, data 0x0000_00FF) → ram_ce_o held 5 cycles with stable addr; d_rdata_o=0xFF; exactly one d_ack_o pulse.
- Timeout: TIMEOUT=16, RAM never acks → d_ack_o and bus_err_o pulse together after 16 busy cycles; d_rdata_o=0; ram_ce_o then 0; a later stray ram_ack_i produces no ack.
- Reset mid-transaction: rst=1 during D_BUSY, then ram_ack_i=1 → all outputs 0 next cycle, no ack pulses; the next request completes normally.
